// File: rtl/rr_pkg.sv
// Shared types and sizing for the rename history table.
// Entry layout and derived depth/segment constants.
package rr_pkg;

  localparam int RHT_ID_WIDTH = 7;
  localparam int K            = 32;
  localparam int C_ADDR       = 2;
  localparam int L_ADDR       = 5;
  localparam int P_ADDR       = 7;
  localparam int DEPTH        = 2**RHT_ID_WIDTH;
  localparam int SEG_BITS     = $clog2(K);

  typedef struct packed {
    logic [L_ADDR-1:0] lreg;
    logic [P_ADDR-1:0] new_preg;
    logic [P_ADDR-1:0] old_preg;
  } rht_entry_t;

endpackage

// File: rtl/rht_ram.sv
// RHT storage: one sync write, one sync walk read,
// one async head read for commit release.
module rht_ram
  import rr_pkg::rht_entry_t;
#(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  rht_entry_t    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output rht_entry_t    rdata,
  input  logic [AW-1:0] caddr,
  output rht_entry_t    cdata
);

  rht_entry_t mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

  assign cdata = mem[caddr];

endmodule

// File: rtl/rename_history_table.sv
// Circular rename history table: program-order rename log
// feeding commit release and the recovery walk.
module rename_history_table
  import rr_pkg::rht_entry_t;
#(
  parameter int RHT_ID_WIDTH = 7,
  parameter int K            = 32,
  parameter int C_ADDR       = 2,
  parameter int L_ADDR       = 5,
  parameter int P_ADDR       = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alloc_en,
  input  logic [L_ADDR-1:0]       alloc_lreg,
  input  logic [P_ADDR-1:0]       alloc_new_preg,
  input  logic [P_ADDR-1:0]       alloc_old_preg,
  output logic                    alloc_ready,
  output logic [RHT_ID_WIDTH-1:0] rht_id_out,
  output logic                    ckpt_take,
  output logic [C_ADDR-1:0]       ckpt_id,
  input  logic                    commit_en,
  output logic                    free_en,
  output logic [P_ADDR-1:0]       free_preg,
  input  logic                    rec_state,
  input  logic                    in_reclaim,
  input  logic [RHT_ID_WIDTH-1:0] walk_point,
  input  logic                    rht_set_ptr,
  input  logic [RHT_ID_WIDTH-1:0] new_pointer,
  output logic                    walk_rd_valid,
  output logic                    walk_rd_reclaim,
  output logic [L_ADDR-1:0]       walk_rd_lreg,
  output logic [P_ADDR-1:0]       walk_rd_new_preg
);

  localparam int DEPTH    = 2**RHT_ID_WIDTH;
  localparam int SEG_BITS = $clog2(K);
  localparam int CW       = RHT_ID_WIDTH + 1;
  localparam logic [CW-1:0] LIMIT = CW'(DEPTH - K);

  logic [RHT_ID_WIDTH-1:0] head;
  logic [RHT_ID_WIDTH-1:0] tail;
  logic [RHT_ID_WIDTH-1:0] head_nx;
  logic [CW-1:0]           count;
  logic                    alloc_fire;
  logic                    commit_fire;
  logic                    set_fire;
  rht_entry_t              wdata;
  rht_entry_t              rdata;
  rht_entry_t              cdata;
  logic                    unused_ok;

  // One segment stays free so a walk base is never overwritten
  assign alloc_ready = !rec_state && (count < LIMIT);
  assign alloc_fire  = alloc_en && alloc_ready;
  assign commit_fire = commit_en && (count != '0);
  assign set_fire    = rht_set_ptr && rec_state;

  assign ckpt_take  = alloc_fire && (tail[SEG_BITS-1:0] == '0);
  assign ckpt_id    = tail[RHT_ID_WIDTH-1:SEG_BITS];
  assign rht_id_out = tail;

  assign free_en   = commit_fire;
  assign free_preg = cdata.old_preg;

  assign head_nx = head + RHT_ID_WIDTH'(commit_fire);

  assign wdata.lreg     = alloc_lreg;
  assign wdata.new_preg = alloc_new_preg;
  assign wdata.old_preg = alloc_old_preg;

  rht_ram #(
    .AW (RHT_ID_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (alloc_fire),
    .waddr (tail),
    .wdata (wdata),
    .re    (rec_state),
    .raddr (walk_point),
    .rdata (rdata),
    .caddr (head),
    .cdata (cdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      walk_rd_valid   <= 1'b0;
      walk_rd_reclaim <= 1'b0;
    end else begin
      head            <= head_nx;
      walk_rd_valid   <= rec_state;
      walk_rd_reclaim <= rec_state && in_reclaim;
      if (set_fire) begin
        tail  <= new_pointer;
        count <= {1'b0, new_pointer - head_nx};
      end else begin
        if (alloc_fire) tail <= tail + 1'b1;
        count <= count + CW'(alloc_fire)
                       - CW'(commit_fire);
      end
    end
  end

  assign walk_rd_lreg     = rdata.lreg;
  assign walk_rd_new_preg = rdata.new_preg;

  assign unused_ok = ^{rdata.old_preg,
                       cdata.lreg,
                       cdata.new_preg};

  always_ff @(posedge clk) begin
    assert (!(commit_en && count == '0));
    assert (!(rht_set_ptr && !rec_state));
  end

endmodule

// File: tb/tb_rename_history_table.sv
// Randomized bench for rename_history_table against a
// ticket-array reference model.
module tb_rename_history_table;

  localparam int D = 128;
  localparam int K = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alloc_en;
  logic [4:0] alloc_lreg;
  logic [6:0] alloc_new_preg;
  logic [6:0] alloc_old_preg;
  logic       alloc_ready;
  logic [6:0] rht_id_out;
  logic       ckpt_take;
  logic [1:0] ckpt_id;
  logic       commit_en;
  logic       free_en;
  logic [6:0] free_preg;
  logic       rec_state;
  logic       in_reclaim;
  logic [6:0] walk_point;
  logic       rht_set_ptr;
  logic [6:0] new_pointer;
  logic       walk_rd_valid;
  logic       walk_rd_reclaim;
  logic [4:0] walk_rd_lreg;
  logic [6:0] walk_rd_new_preg;

  int errs   = 0;
  int checks = 0;

  int m_lreg [D];
  int m_new  [D];
  int m_old  [D];
  int m_head, m_tail, m_cnt;
  bit p_v, p_rc;
  int p_l, p_n;

  rename_history_table dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alloc_en         (alloc_en),
    .alloc_lreg       (alloc_lreg),
    .alloc_new_preg   (alloc_new_preg),
    .alloc_old_preg   (alloc_old_preg),
    .alloc_ready      (alloc_ready),
    .rht_id_out       (rht_id_out),
    .ckpt_take        (ckpt_take),
    .ckpt_id          (ckpt_id),
    .commit_en        (commit_en),
    .free_en          (free_en),
    .free_preg        (free_preg),
    .rec_state        (rec_state),
    .in_reclaim       (in_reclaim),
    .walk_point       (walk_point),
    .rht_set_ptr      (rht_set_ptr),
    .new_pointer      (new_pointer),
    .walk_rd_valid    (walk_rd_valid),
    .walk_rd_reclaim  (walk_rd_reclaim),
    .walk_rd_lreg     (walk_rd_lreg),
    .walk_rd_new_preg (walk_rd_new_preg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got,
                     input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr_inputs();
    alloc_en       = 1'b0;
    alloc_lreg     = '0;
    alloc_new_preg = '0;
    alloc_old_preg = '0;
    commit_en      = 1'b0;
    rec_state      = 1'b0;
    in_reclaim     = 1'b0;
    walk_point     = '0;
    rht_set_ptr    = 1'b0;
    new_pointer    = '0;
  endtask

  task automatic model_reset();
    m_head = 0;
    m_tail = 0;
    m_cnt  = 0;
    p_v    = 1'b0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_alloc();
    alloc_en       = 1'b1;
    alloc_lreg     = 5'($urandom);
    alloc_new_preg = 7'($urandom);
    alloc_old_preg = 7'($urandom);
  endtask

  // One cycle: check outputs, clock, then advance the model
  task automatic step();
    bit rdy, af, cf, seg;
    #1;
    rdy = !rec_state && (m_cnt < D - K);
    af  = alloc_en && rdy;
    cf  = commit_en && (m_cnt != 0);
    seg = af && (m_tail % K == 0);
    chk("alloc_ready", alloc_ready, rdy);
    chk("ckpt_take", ckpt_take, seg);
    if (seg) chk("ckpt_id", ckpt_id, m_tail / K);
    chk("rht_id_out", rht_id_out, m_tail);
    chk("free_en", free_en, cf);
    if (cf) chk("free_preg", free_preg, m_old[m_head]);
    chk("walk_valid", walk_rd_valid, p_v);
    if (p_v) begin
      chk("walk_reclaim", walk_rd_reclaim, p_rc);
      chk("walk_lreg", walk_rd_lreg, p_l);
      chk("walk_new", walk_rd_new_preg, p_n);
    end
    @(posedge clk);
    p_v  = rec_state;
    p_rc = in_reclaim;
    if (rec_state) begin
      p_l = m_lreg[walk_point];
      p_n = m_new[walk_point];
    end
    if (af) begin
      m_lreg[m_tail] = alloc_lreg;
      m_new[m_tail]  = alloc_new_preg;
      m_old[m_tail]  = alloc_old_preg;
    end
    if (cf) m_head = (m_head + 1) % D;
    if (rht_set_ptr && rec_state) begin
      m_tail = new_pointer;
      m_cnt  = (int'(new_pointer) - m_head + D) % D;
    end else begin
      if (af) m_tail = (m_tail + 1) % D;
      m_cnt = m_cnt + int'(af) - int'(cf);
    end
    #1;
  endtask

  initial begin
    int n;
    do_reset();
    chk("rst_id", rht_id_out, 0);
    chk("rst_valid", walk_rd_valid, 0);
    chk("rst_free", free_en, 0);

    for (int i = 0; i < 3; i++) begin
      alloc_en       = 1'b1;
      alloc_lreg     = 5'(i + 1);
      alloc_new_preg = 7'(40 + i);
      alloc_old_preg = 7'(10 + i);
      step();
    end
    alloc_en = 1'b0;
    chk("id_after3", rht_id_out, 3);

    commit_en = 1'b1;
    #1;
    chk("free_first", free_preg, 10);
    step();
    #1;
    chk("free_second", free_preg, 11);
    step();
    rand_alloc();
    step();
    commit_en = 1'b0;

    n = 0;
    while (m_cnt < D - K && n < 200) begin
      rand_alloc();
      step();
      n++;
    end
    alloc_en = 1'b1;
    #1;
    chk("full_ready", alloc_ready, 0);
    step();
    alloc_en  = 1'b0;
    commit_en = 1'b1;
    step();
    commit_en = 1'b0;
    #1;
    chk("reraise", alloc_ready, 1);

    do_reset();
    for (int i = 0; i < 40; i++) begin
      rand_alloc();
      step();
    end
    alloc_en  = 1'b0;
    commit_en = 1'b1;
    repeat (10) step();
    commit_en = 1'b0;
    rec_state = 1'b1;
    for (int t = 32; t < 40; t++) begin
      rand_alloc();
      walk_point  = 7'(t);
      in_reclaim  = (t >= 36);
      rht_set_ptr = (t == 39);
      new_pointer = 7'd36;
      step();
    end
    rht_set_ptr = 1'b0;
    walk_point  = '0;
    step();
    chk("redir_id", rht_id_out, 36);
    chk("redir_block", alloc_ready, 0);
    rec_state  = 1'b0;
    in_reclaim = 1'b0;
    step();
    alloc_en = 1'b0;
    step();

    do_reset();
    for (int i = 0; i < 13; i++) begin
      rand_alloc();
      step();
    end
    commit_en = 1'b1;
    repeat (120) begin
      rand_alloc();
      step();
    end
    alloc_en  = 1'b0;
    commit_en = 1'b0;
    chk("wrap_tail", rht_id_out, 5);
    rec_state  = 1'b1;
    in_reclaim = 1'b1;
    walk_point = 7'd2;
    step();
    walk_point  = 7'd3;
    rht_set_ptr = 1'b1;
    new_pointer = 7'd1;
    step();
    rht_set_ptr = 1'b0;
    step();
    rec_state  = 1'b0;
    in_reclaim = 1'b0;
    step();
    n = 0;
    while (alloc_ready && n < 200) begin
      rand_alloc();
      step();
      n++;
    end
    alloc_en = 1'b0;
    chk("wrap_fill", n, 87);

    repeat (300) begin
      alloc_en       = 1'($urandom);
      alloc_lreg     = 5'($urandom);
      alloc_new_preg = 7'($urandom);
      alloc_old_preg = 7'($urandom);
      commit_en      = (m_cnt > 0) && ($urandom % 2 == 0);
      step();
    end
    clr_inputs();

    rec_state  = 1'b1;
    in_reclaim = 1'b1;
    repeat (3) begin
      walk_point = 7'($urandom);
      step();
    end
    commit_en = (m_cnt > 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_id", rht_id_out, 0);
    chk("mid_rst_valid", walk_rd_valid, 0);
    chk("mid_rst_free", free_en, 0);
    clr_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) begin
      rand_alloc();
      step();
    end
    alloc_en = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/rename_history_table.md
# rename_history_table

Circular rename history table (RHT) that records every destination rename in program order and serves the recovery walk FSM. It sits between the rename stage (writer), the commit stage (head release to the free list), and the walk FSM. The walk FSM reads entries by ticket and redirects the tail when recovery completes. The table also flags checkpoint-boundary allocations so the RAT captures a checkpoint every K entries.

## Interface
- RHT_ID_WIDTH, 7: ticket width; depth = 2^RHT_ID_WIDTH entries.
- K, 32: checkpoint period; power of two, divides depth.
- C_ADDR, 2: checkpoint index width; must equal RHT_ID_WIDTH - log2(K).
- L_ADDR, 5: architectural register index width.
- P_ADDR, 7: physical register index width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alloc_en  in  1  rename writes one entry this cycle; honoured only when alloc_ready=1.
- alloc_lreg  in  L_ADDR  architectural destination.
- alloc_new_preg  in  P_ADDR  newly mapped physical register.
- alloc_old_preg  in  P_ADDR  previous mapping.
- alloc_ready  out  1  entry can be written.
- rht_id_out  out  RHT_ID_WIDTH  tail pointer, the ticket the next allocation receives.
- ckpt_take  out  1  the allocation this cycle sits at a segment base.
- ckpt_id  out  C_ADDR  checkpoint slot for ckpt_take, equal to tail[RHT_ID_WIDTH-1:log2(K)].
- commit_en  in  1  retire the head entry.
- free_en  out  1  head entry released this cycle.
- free_preg  out  P_ADDR  old_preg of the released entry.
- rec_state  in  1  walk active.
- in_reclaim  in  1  walk is in reclaim phase.
- walk_point  in  RHT_ID_WIDTH  ticket read by the walk.
- rht_set_ptr  in  1  redirect tail.
- new_pointer  in  RHT_ID_WIDTH  new tail value.
- walk_rd_valid  out  1  walk read data valid.
- walk_rd_reclaim  out  1  1 = reclaim entry (free new_preg); 0 = restore entry (replay into RAT).
- walk_rd_lreg  out  L_ADDR  entry architectural register.
- walk_rd_new_preg  out  P_ADDR  entry new physical register.

## Operation
- State: head, tail (RHT_ID_WIDTH, wrap mod depth), count (RHT_ID_WIDTH+1 bits), and the entry storage.
- Reset values: head=0, tail=0, count=0, and all registered outputs 0. Storage contents are don't-care.
- alloc_ready = !rec_state && (count < depth - K).
  - One full segment is always kept unwritten, so the segment base of the oldest in-flight ticket is never overwritten while a restore walk may start there.
- Allocation: write {lreg,new_preg,old_preg} at tail; tail+1; count+1.
  - ckpt_take = alloc_en && alloc_ready && tail[log2(K)-1:0]==0. It is combinational in the same cycle.
- Commit: when commit_en && count!=0, assert free_en with free_preg=old_preg[head], then head+1 and count-1. Both outputs are combinational from head.
  - commit_en with count==0 is ignored, and an assertion fires.
- Commit is permitted during rec_state, since committing entries are older than the recovery target.
- Walk read: when rec_state, read entry[walk_point]. On the next cycle, drive walk_rd_valid=1, walk_rd_reclaim equal to the registered in_reclaim, and the entry fields. Otherwise walk_rd_valid=0.
- Redirect: on rht_set_ptr, tail <= new_pointer and count <= new_pointer - head_next, computed mod depth. head_next accounts for a commit in the same cycle.
  - rht_set_ptr while rec_state=0 is ignored, and an assertion fires.
- Same-cycle allocation and commit: count is unchanged; both pointers advance.

## Timing
- Allocation and commit take effect at the clock edge. rht_id_out updates in the cycle after the write.
- Walk read latency is exactly 1 cycle, which gives one output per walk_point per cycle, back to back.
- The last reclaim read (walk_point = tail-1) coincides with rht_set_ptr. Its data emerges the next cycle, when the tail has already been redirected. Stored data stays intact because the slot is not rewritten until allocation resumes, and allocation resumes no earlier than the cycle after rec_state drops.
- Wrap-around: pointers roll from depth-1 to 0 without special cases. Full and empty are judged only by count.
- If rst_n asserts mid-walk, pointers clear immediately (asynchronously) and walk_rd_valid drops to 0.

## Structure
- Shared package rr_pkg holds:
  - rht_entry_t, a packed struct {lreg, new_preg, old_preg};
  - the derived localparams DEPTH = 2**RHT_ID_WIDTH and SEG_BITS = $clog2(K).
- Sub-module rht_ram: DEPTH x rht_entry_t, one synchronous write port, one synchronous read port (walk), one asynchronous read port (head/commit).

## Test plan
- Reset, then 3 allocations (lreg 1/2/3, new 40/41/42, old 10/11/12) -> rht_id_out=3. ckpt_take=1 only on the first allocation, with ckpt_id=0.
- Next, commit twice -> free_preg 10 then 11, free_en=1 each cycle; allocation and commit in the same cycle keep count unchanged.
- Allocate continuously with no commit -> alloc_ready drops at count=96 (depth 128, K 32). A single commit reraises it.
- Recovery: tail=40, target 35, walk from 32 -> walk_rd_reclaim=0 for tickets 32..35 and 1 for 36..39, one per cycle with 1-cycle latency. new_pointer=36 -> rht_id_out=36, and allocation blocked until rec_state=0.
- Wrap-around: head=120, tail=5, ticket 2 walk read -> correct data; redirect to 1 -> count=9.
- Assert rst_n mid-walk -> rht_id_out=0, walk_rd_valid=0, free_en=0 immediately.
